// File: rtl/dmem_ctrl.sv
// Purpose : byte-addressed data memory (byte/half/word, sign/zero extend) for the MEM stage.
// Latency : LATENCY+1 cycles from accept to rsp_valid; 1 cycle for erroneous requests.
// Backpr. : one request outstanding; req_ready low until the response is taken via rsp_ready.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            request handshake
//   req_we, req_size, req_unsigned request kind (store, 00 byte / 01 half / 10 word, zero-extend)
//   req_addr, req_wdata            byte address, store data (low-order bytes)
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata, rsp_err             extended load data (0 for stores/errors), error flag
module dmem_ctrl #(
  parameter int    DEPTH     = 100,
  parameter int    LATENCY   = 0,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam int          IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);
  localparam logic [3:0]  LAT4  = 4'(LATENCY);

  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  req_t        in_req, cur;
  logic        accept, cur_err, do_access, do_write;
  logic [IW-1:0] idx;
  logic [1:0]  lane;
  logic [31:0] rd_word, load_data, wr_word;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  assign in_req = '{we: req_we, size: req_size, uns: req_unsigned,
                    addr: req_addr, wdata: req_wdata};
  // rst_n gates accept so a request held during reset can never write the array.
  assign accept = rst_n && req_valid && req_ready_q && (state_q == IDLE);

  // With LATENCY = 0 the access happens on the accept edge itself, so the
  // datapath must look at the live inputs in IDLE and the latched copy later.
  assign cur  = (state_q == IDLE) ? in_req : req_q;
  assign idx  = cur.addr[IW+1:2];
  assign lane = cur.addr[1:0];

  assign cur_err = (cur.size == 2'b11) ||
                   (cur.size == 2'b01 && cur.addr[0]) ||
                   (cur.size == 2'b10 && cur.addr[1:0] != 2'b00) ||
                   (cur.addr >= LIMIT);

  always_comb begin
    rd_word   = mem[idx];
    sel_b     = rd_word[{lane, 3'b000} +: 8];
    sel_h     = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    wr_word   = rd_word;
    case (cur.size)
      2'b00: begin
        load_data = {{24{~cur.uns & sel_b[7]}}, sel_b};
        wr_word[{lane, 3'b000} +: 8] = cur.wdata[7:0];
      end
      2'b01: begin
        load_data = {{16{~cur.uns & sel_h[15]}}, sel_h};
        wr_word[{lane[1], 4'b0000} +: 16] = cur.wdata[15:0];
      end
      default: wr_word = cur.wdata;
    endcase
  end

  assign do_access = (accept && !cur_err && LATENCY == 0) ||
                     (state_q == WAIT && cnt_q == 4'd0);
  assign do_write  = do_access && cur.we;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d = in_req;
          if (cur_err) begin
            // Errors skip the wait states entirely.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else if (LATENCY == 0) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = cur.we ? 32'd0 : load_data;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT4 - 4'd1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = cur.we ? 32'd0 : load_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array contents survive reset, so the write port has no reset branch.
  always_ff @(posedge clk) begin
    if (do_write) mem[idx] <= wr_word;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v3 = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_ready = 1'b0;

  logic        rdy0, rdy3, rv0, rv3, er0, er3;
  logic [31:0] rd0, rd3;

  logic        sel = 1'b0;  // 0 -> LATENCY 0 instance, 1 -> LATENCY 3 instance
  logic        ready_s, rv_s, err_s;
  logic [31:0] rdata_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH(100), .LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(er0));

  dmem_ctrl #(.DEPTH(100), .LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_rdata(rd3), .rsp_err(er3));

  assign ready_s = sel ? rdy3 : rdy0;
  assign rv_s    = sel ? rv3  : rv0;
  assign err_s   = sel ? er3  : er0;
  assign rdata_s = sel ? rd3  : rd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One request on the selected instance; called at posedge+1.
  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er, output int lat,
                      output logic rdy_low, output logic stable);
    int n;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    if (sel) v3 = 1'b1; else v0 = 1'b1;
    n = 0;
    while (!ready_s && n < 50) begin @(posedge clk); #1; n++; end
    if (!ready_s) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    v0 = 1'b0; v3 = 1'b0;
    // Scramble inputs: they must have no effect after the accept edge.
    req_we = ~we; req_addr = a ^ 32'h4; req_wdata = ~wd; req_unsigned = ~uns;
    lat = 1; rdy_low = 1'b1;
    while (!rv_s && lat < 50) begin
      if (ready_s) rdy_low = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (!rv_s) chk("rsp_timeout", 32'd0, 32'd1);
    if (ready_s) rdy_low = 1'b0;
    rd = rdata_s; er = err_s; stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!rv_s || rdata_s !== rd || err_s !== er || ready_s) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    logic [31:0] rd; logic er, rl, st; int lat;
    xact(we, sz, uns, a, wd, 0, rd, er, lat, rl, st);
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".err"}, {31'd0, er}, {31'd0, exp_err});
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".vld_clr"}, {31'd0, rv_s}, 32'd0);
  endtask

  // Hold req_valid high with rsp_ready = 1; expect accepts every gap cycles.
  task automatic b2b(input string tag, input int gap);
    int acc_cyc[4]; int n_acc, n_rsp; logic acc, hs;
    n_acc = 0; n_rsp = 0;
    rsp_ready = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20;
    if (sel) v3 = 1'b1; else v0 = 1'b1;
    for (int c = 0; c < 60 && n_rsp < 3; c++) begin
      acc = (v0 | v3) && ready_s;
      hs  = rv_s && rsp_ready;
      if (hs) begin
        chk({tag, ".data"}, rdata_s, 32'h11110001 + 32'(n_rsp));
        n_rsp++;
      end
      if (acc) begin acc_cyc[n_acc] = c; n_acc++; end
      @(posedge clk); #1;
      if (acc) begin
        if (n_acc == 3) begin v0 = 1'b0; v3 = 1'b0; end
        else req_addr = 32'h20 + 32'(4 * n_acc);
      end
    end
    v0 = 1'b0; v3 = 1'b0; rsp_ready = 1'b0;
    chk({tag, ".nrsp"}, n_rsp, 3);
    if (n_acc == 3) begin
      chk({tag, ".gap1"}, acc_cyc[1] - acc_cyc[0], gap);
      chk({tag, ".gap2"}, acc_cyc[2] - acc_cyc[1], gap);
    end else chk({tag, ".nacc"}, n_acc, 3);
  endtask

  initial begin
    logic [31:0] rd; logic er, rl, st; int lat;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready0", {31'd0, rdy0}, 32'd1);
    chk("rst.ready3", {31'd0, rdy3}, 32'd1);
    chk("rst.valid",  {30'd0, rv0, rv3}, 32'd0);
    chk("rst.rdata",  rd0 | rd3, 32'd0);
    chk("rst.err",    {30'd0, er0, er3}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LATENCY 0 instance
    sel = 1'b0;
    run("t1.st_w",  1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 32'h0, 0, 1);
    run("t1.ld_w",  0, 2'b10, 0, 32'h08, 32'h0, 32'hDEADBEEF, 0, 1);
    run("t2.st_b",  1, 2'b00, 0, 32'h09, 32'hFFFFFF80, 32'h0, 0, 1);
    run("t2.ld_bs", 0, 2'b00, 0, 32'h09, 32'h0, 32'hFFFFFF80, 0, 1);
    run("t2.ld_bu", 0, 2'b00, 1, 32'h09, 32'h0, 32'h00000080, 0, 1);
    run("t2.ld_w",  0, 2'b10, 0, 32'h08, 32'h0, 32'hDEAD80EF, 0, 1);
    run("t2.ld_hs", 0, 2'b01, 0, 32'h0A, 32'h0, 32'hFFFFDEAD, 0, 1);
    run("t2.ld_hu", 0, 2'b01, 1, 32'h0A, 32'h0, 32'h0000DEAD, 0, 1);
    run("t2.ld_hl", 0, 2'b01, 0, 32'h08, 32'h0, 32'hFFFF80EF, 0, 1);
    run("t2.ld_wu", 0, 2'b10, 1, 32'h08, 32'h0, 32'hDEAD80EF, 0, 1);
    run("t2.st_h",  1, 2'b01, 0, 32'h0A, 32'hAAAA1234, 32'h0, 0, 1);
    run("t2.ld_w2", 0, 2'b10, 0, 32'h08, 32'h0, 32'h123480EF, 0, 1);
    run("t2.ld_b3", 0, 2'b00, 1, 32'h0B, 32'h0, 32'h00000012, 0, 1);
    run("t3.ld_h",  0, 2'b01, 0, 32'h0B, 32'h0, 32'h0, 1, 1);
    run("t3.st_hm", 1, 2'b01, 0, 32'h09, 32'h5555, 32'h0, 1, 1);
    run("t3.st_wm", 1, 2'b10, 0, 32'h0A, 32'h66666666, 32'h0, 1, 1);
    run("t3.st_rs", 1, 2'b11, 0, 32'h08, 32'h77777777, 32'h0, 1, 1);
    run("t3.ld_w3", 0, 2'b10, 0, 32'h08, 32'h0, 32'h123480EF, 0, 1);
    run("t3.st_lw", 1, 2'b10, 0, 32'h18C, 32'h0BADF00D, 32'h0, 0, 1);
    run("t3.st_or", 1, 2'b10, 0, 32'h190, 32'h99999999, 32'h0, 1, 1);
    run("t3.ld_or", 0, 2'b00, 0, 32'h190, 32'h0, 32'h0, 1, 1);
    run("t3.ld_lw", 0, 2'b10, 0, 32'h18C, 32'h0, 32'h0BADF00D, 0, 1);
    run("t3.ld_w0", 0, 2'b10, 0, 32'h00, 32'h0, 32'h0, 0, 1);
    run("t6.pre0",  1, 2'b10, 0, 32'h20, 32'h11110001, 32'h0, 0, 1);
    run("t6.pre1",  1, 2'b10, 0, 32'h24, 32'h11110002, 32'h0, 0, 1);
    run("t6.pre2",  1, 2'b10, 0, 32'h28, 32'h11110003, 32'h0, 0, 1);
    b2b("t6.l0", 2);

    // LATENCY 3 instance
    sel = 1'b1;
    run("t4.st_w",  1, 2'b10, 0, 32'h08, 32'hCAFEF00D, 32'h0, 0, 4);
    xact(0, 2'b10, 0, 32'h08, 32'h0, 5, rd, er, lat, rl, st);
    chk("t4.rdata",  rd, 32'hCAFEF00D);
    chk("t4.lat",    lat, 4);
    chk("t4.rdylow", {31'd0, rl}, 32'd1);
    chk("t4.stable", {31'd0, st}, 32'd1);
    run("t4.ld_err", 0, 2'b01, 0, 32'h09, 32'h0, 32'h0, 1, 1);
    run("t4.ld_bs",  0, 2'b00, 0, 32'h0A, 32'h0, 32'hFFFFFFFE, 0, 4);

    run("t5.st_old", 1, 2'b10, 0, 32'h10, 32'hA5A5A5A5, 32'h0, 0, 4);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h11223344; v3 = 1'b1;
    @(posedge clk); #1;            // accept edge; first WAIT cycle
    v3 = 1'b0;
    chk("t5.accepted", {31'd0, rdy3}, 32'd0);
    @(posedge clk); #1;            // second WAIT cycle
    rst_n = 1'b0;
    #1;
    chk("t5.rst_ready", {31'd0, rdy3}, 32'd1);
    chk("t5.rst_valid", {31'd0, rv3}, 32'd0);
    chk("t5.rst_rdata", rd3, 32'd0);
    chk("t5.rst_err",   {31'd0, er3}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("t5.rst_hold",  {31'd0, rv3}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("t5.ld_old", 0, 2'b10, 0, 32'h10, 32'h0, 32'hA5A5A5A5, 0, 4);

    run("t6.pre0b", 1, 2'b10, 0, 32'h20, 32'h11110001, 32'h0, 0, 4);
    run("t6.pre1b", 1, 2'b10, 0, 32'h24, 32'h11110002, 32'h0, 0, 4);
    run("t6.pre2b", 1, 2'b10, 0, 32'h28, 32'h11110003, 32'h0, 0, 4);
    b2b("t6.l3", 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
